// File: rtl/flash_burst_reader.sv
// Read controller for the parallel NOR flash: Read-Array command over WE#, then single/burst word reads.
// Optional macro FLASH_RD_CACHE_EN adds a single-entry last-word cache.
module flash_burst_reader #(
    parameter int unsigned ADDR_W         = 22,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned LEN_W          = 4,
    parameter int unsigned WE_CYCLES      = 1,
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter int unsigned SWAP           = 1,
    parameter int unsigned CMD_EVERY_READ = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              flash_ce,
    output logic              flash_we,
    output logic              flash_oe,
    output logic              flash_rp,
    output logic              flash_byte,
    output logic              flash_vpen,
    output logic [ADDR_W-1:0] flash_addr,
    inout  wire  [DATA_W-1:0] flash_data
);
    localparam int unsigned CNT_MAX = (WE_CYCLES > WAIT_CYCLES) ? WE_CYCLES : WAIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DATA_W-1:0] READ_ARRAY = DATA_W'(16'h00FF);

    typedef enum logic [3:0] {
        IDLE, CMD_WE, CMD_HOLD, CMD_REL, RD_ADDR, RD_WAIT, RD_CAP, RD_END, HIT, HIT_END
    } state_t;

    state_t            state_q, state_d;
    logic              busy_d, valid_d, done_d, we_d, oe_d;
    logic              drive_q, drive_d, array_q, array_d;
    logic [DATA_W-1:0] rdata_d, cap_word;
    logic [ADDR_W-1:0] flash_addr_d, cur_q, cur_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hit_c;

    assign flash_ce   = 1'b0;
    assign flash_rp   = 1'b1;
    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_data = drive_q ? READ_ARRAY : {DATA_W{1'bz}};

    generate
        if (SWAP != 0) begin : g_swap
            assign cap_word = {flash_data[7:0], flash_data[DATA_W-1:8]};
        end else begin : g_pass
            assign cap_word = flash_data;
        end
    endgenerate

`ifdef FLASH_RD_CACHE_EN
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] cache_q;
    logic              cache_vld_q;

    assign hit_c = cache_vld_q && array_q && (burst_len == '0) && (addr == tag_q);

    // Every flash capture refreshes the cached word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q       <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
        end else if (state_q == RD_CAP) begin
            tag_q       <= cur_q;
            cache_q     <= cap_word;
            cache_vld_q <= 1'b1;
        end
    end
`else
    assign hit_c = 1'b0;
`endif

    // Next state and next registered outputs; strobes default low, levels hold
    always_comb begin
        state_d      = state_q;
        busy_d       = busy;
        rdata_d      = rdata;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        we_d         = flash_we;
        oe_d         = flash_oe;
        drive_d      = drive_q;
        array_d      = array_q;
        flash_addr_d = flash_addr;
        cur_d        = cur_q;
        words_d      = words_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cur_d   = addr;
                    words_d = burst_len;
                    busy_d  = 1'b1;
                    if (hit_c) begin
                        state_d = HIT;
                    end else if (!array_q || (CMD_EVERY_READ != 0)) begin
                        state_d = CMD_WE;
                        we_d    = 1'b0;
                        drive_d = 1'b1;
                    end else begin
                        state_d      = RD_ADDR;
                        oe_d         = 1'b0;
                        flash_addr_d = addr;
                    end
                end
            end
            CMD_WE: begin
                cnt_d   = CNT_W'(WE_CYCLES);
                state_d = CMD_HOLD;
            end
            CMD_HOLD: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = CMD_REL;
                    we_d    = 1'b1;
                    array_d = 1'b1;
                end
            end
            CMD_REL: begin
                state_d      = RD_ADDR;
                drive_d      = 1'b0;
                oe_d         = 1'b0;
                flash_addr_d = cur_q;
            end
            RD_ADDR: begin
                cnt_d   = CNT_W'(WAIT_CYCLES);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RD_CAP;
                end
            end
            RD_CAP: begin
                rdata_d = cap_word;
                valid_d = 1'b1;
                if (words_q != '0) begin
                    words_d      = words_q - LEN_W'(1);
                    cur_d        = cur_q + ADDR_W'(1);
                    flash_addr_d = cur_q + ADDR_W'(1);
                    state_d      = RD_ADDR;
                end else begin
                    done_d  = 1'b1;
                    oe_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RD_END;
                end
            end
            RD_END: begin
                state_d = IDLE;
            end
`ifdef FLASH_RD_CACHE_EN
            HIT: begin
                busy_d  = 1'b0;
                state_d = HIT_END;
            end
            HIT_END: begin
                rdata_d = cache_q;
                valid_d = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            flash_we    <= 1'b1;
            flash_oe    <= 1'b1;
            flash_addr  <= '0;
            drive_q     <= 1'b0;
            array_q     <= 1'b0;
            cur_q       <= '0;
            words_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy        <= busy_d;
            rdata       <= rdata_d;
            rdata_valid <= valid_d;
            done        <= done_d;
            flash_we    <= we_d;
            flash_oe    <= oe_d;
            flash_addr  <= flash_addr_d;
            drive_q     <= drive_d;
            array_q     <= array_d;
            cur_q       <= cur_d;
            words_q     <= words_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_flash_burst_reader.sv
// Scoreboard bench for flash_burst_reader with a behavioural NOR flash read model.
module tb_flash_burst_reader;
    localparam int unsigned ADDR_W      = 22;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned WE_CYCLES   = 1;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam int LAT_CMD = 4 + WE_CYCLES + WAIT_CYCLES;
    localparam int LAT_RD  = 2 + WAIT_CYCLES;
    localparam int STEP    = 2 + WAIT_CYCLES;
    localparam int PERIOD  = LAT_RD + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic              busy, rdata_valid, done;
    logic [DATA_W-1:0] rdata;
    logic              flash_ce, flash_we, flash_oe, flash_rp, flash_byte, flash_vpen;
    logic [ADDR_W-1:0] flash_addr;
    wire  [DATA_W-1:0] flash_data;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [31:0] cyc;
    } exp_t;

    exp_t              sb[$];
    logic [ADDR_W-1:0] addr_log[$];
    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;
    int                we_low = 0;
    int                oe_low = 0;
    int                cmd_bad = 0;
    logic              prev_oe_low = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    flash_burst_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .WE_CYCLES(WE_CYCLES),
        .WAIT_CYCLES(WAIT_CYCLES), .SWAP(1), .CMD_EVERY_READ(0)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .burst_len(burst_len),
        .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
        .flash_ce(flash_ce), .flash_we(flash_we), .flash_oe(flash_oe), .flash_rp(flash_rp),
        .flash_byte(flash_byte), .flash_vpen(flash_vpen), .flash_addr(flash_addr),
        .flash_data(flash_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem(input logic [ADDR_W-1:0] a);
        if (a == 22'h000010) return 16'h3412;
        return {a[7:0] ^ 8'h96, a[15:8] ^ {2'b00, a[21:16]} ^ 8'h3C};
    endfunction

    function automatic logic [15:0] expw(input logic [ADDR_W-1:0] a);
        logic [15:0] m;
        m = mem(a);
        return {m[7:0], m[15:8]};
    endfunction

    assign flash_data = (flash_oe == 1'b0) ? mem(flash_addr) : 16'hzzzz;

    // Scoreboard and pin monitor
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (!flash_we && !flash_oe) begin
            errors++;
            $display("FAIL we_oe_overlap: got we=%b oe=%b at cycle %0d, required never both low", flash_we, flash_oe, cyc);
        end
        if (!flash_we) begin
            we_low++;
            if (flash_data !== 16'h00FF) cmd_bad++;
        end
        if (!flash_oe) begin
            oe_low++;
            if (!prev_oe_low || flash_addr != prev_addr) addr_log.push_back(flash_addr);
        end
        prev_oe_low = !flash_oe;
        prev_addr   = flash_addr;
        if (rdata_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rdata=%h at cycle %0d, required no output", rdata, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (rdata !== e.data) begin
                    errors++;
                    $display("FAIL rdata: got %h required %h", rdata, e.data);
                end
                checks++;
                if (done !== e.last) begin
                    errors++;
                    $display("FAIL done_flag: got %b required %b", done, e.last);
                end
                checks++;
                if (cyc !== int'(e.cyc)) begin
                    errors++;
                    $display("FAIL valid_cycle: got %0d required %0d", cyc, e.cyc);
                end
            end
        end else if (done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid: got done=1 at cycle %0d, required 0", cyc);
        end
    end

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                         input int first_lat, output int acc);
        @(negedge clk);
        addr      = a;
        burst_len = len;
        req       = 1'b1;
        acc       = cyc + 1;
        for (int i = 0; i <= int'(len); i++) begin
            exp_t e;
            e.data = expw(a + ADDR_W'(i));
            e.last = (i == int'(len));
            e.cyc  = 32'(acc + first_lat + i * STEP);
            sb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain(output bit to);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        to = (sb.size() != 0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, rdata_valid, done, flash_we, flash_oe} !== 5'b00011) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00011", {busy, rdata_valid, done, flash_we, flash_oe});
        end
        checks++;
        if (rdata !== 16'h0000 || flash_addr !== 22'h0) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h addr=%h required 0/0", rdata, flash_addr);
        end
        checks++;
        if ({flash_ce, flash_rp, flash_byte, flash_vpen} !== 4'b0111) begin
            errors++;
            $display("FAIL tie_offs: got %b required 0111", {flash_ce, flash_rp, flash_byte, flash_vpen});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cmd_first();
        int acc, we0, bad0;
        bit to;
        we0  = we_low;
        bad0 = cmd_bad;
        issue(22'h000010, 4'd0, LAT_CMD, acc);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cmd_busy: got %b required 1", busy);
        end
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL cmd_timeout: got pending words required none"); end
        checks++;
        if (we_low - we0 !== 1 + WE_CYCLES) begin
            errors++;
            $display("FAIL cmd_we_len: got %0d required %0d", we_low - we0, 1 + WE_CYCLES);
        end
        checks++;
        if (cmd_bad - bad0 !== 0) begin
            errors++;
            $display("FAIL cmd_data: got %0d bad cycles required 0", cmd_bad - bad0);
        end
        checks++;
        if (rdata !== 16'h1234 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cmd_result: got rdata=%h busy=%b required 1234/0", rdata, busy);
        end
    endtask

    task automatic test_burst();
        int acc, we0, lb;
        bit to;
        we0 = we_low;
        lb  = addr_log.size();
        issue(22'h000020, 4'd3, LAT_RD, acc);
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL burst_timeout: got pending words required none"); end
        checks++;
        if (we_low - we0 !== 0) begin
            errors++;
            $display("FAIL burst_no_cmd: got %0d we-low cycles required 0", we_low - we0);
        end
        checks++;
        if (addr_log.size() - lb !== 4) begin
            errors++;
            $display("FAIL burst_addr_count: got %0d required 4", addr_log.size() - lb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_log[lb + i] !== 22'h000020 + ADDR_W'(i)) begin
                    errors++;
                    $display("FAIL burst_addr: got %h required %h", addr_log[lb + i], 22'h000020 + ADDR_W'(i));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int acc, lb;
        bit to;
        lb = addr_log.size();
        issue(22'h3FFFFF, 4'd1, LAT_RD, acc);
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL wrap_timeout: got pending words required none"); end
        checks++;
        if (addr_log.size() - lb !== 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d required 2", addr_log.size() - lb);
        end else begin
            checks++;
            if (addr_log[lb] !== 22'h3FFFFF || addr_log[lb + 1] !== 22'h000000) begin
                errors++;
                $display("FAIL wrap_addr: got %h,%h required 3fffff,000000", addr_log[lb], addr_log[lb + 1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc, n, we0;
        bit to;
        issue(22'h000040, 4'd3, LAT_RD, acc);
        // Only the first word completes before the reset lands
        while (sb.size() > 1) void'(sb.pop_back());
        n = 0;
        while (cyc != acc + PERIOD - 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, rdata_valid, done, flash_we, flash_oe} !== 5'b00011) begin
            errors++;
            $display("FAIL midreset_ctrl: got %b required 00011", {busy, rdata_valid, done, flash_we, flash_oe});
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midreset_word0: got %0d pending required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        we0 = we_low;
        issue(22'h000040, 4'd0, LAT_CMD, acc);
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL midreset_timeout: got pending words required none"); end
        checks++;
        if (we_low - we0 !== 1 + WE_CYCLES) begin
            errors++;
            $display("FAIL midreset_recmd: got %0d we-low cycles required %0d", we_low - we0, 1 + WE_CYCLES);
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] al[4];
        int a0, n;
        bit to;
        al[0] = 22'h000100; al[1] = 22'h000200; al[2] = 22'h000300; al[3] = 22'h000155;
        @(negedge clk);
        addr      = al[0];
        burst_len = '0;
        req       = 1'b1;
        a0        = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.data = expw(al[k]);
            e.last = 1'b1;
            e.cyc  = 32'(a0 + k * PERIOD + LAT_RD);
            sb.push_back(e);
        end
        n = 0;
        while (req && n < 40) begin
            @(negedge clk);
            n++;
            if (cyc == a0) addr = al[1];
            if (cyc == a0 + PERIOD) addr = al[2];
            if (cyc == a0 + 2 * PERIOD) begin
                addr = al[3];
                req  = 1'b0;
            end
        end
        checks++;
        if (req) begin
            errors++;
            $display("FAIL b2b_window: got req still high required drop after third accept");
            req = 1'b0;
        end
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL b2b_timeout: got pending words required none"); end
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_cache();
        int acc, o0, lat, oe_exp;
        logic busy2;
        bit to;
        issue(22'h000010, 4'd0, LAT_RD, acc);
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL cache_prime_timeout: got pending words required none"); end
`ifdef FLASH_RD_CACHE_EN
        lat = 2; oe_exp = 0; busy2 = 1'b0;
`else
        lat = LAT_RD; oe_exp = 2 + WAIT_CYCLES; busy2 = 1'b1;
`endif
        o0 = oe_low;
        issue(22'h000010, 4'd0, lat, acc);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL repeat_busy0: got %b required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== busy2) begin
            errors++;
            $display("FAIL repeat_busy1: got %b required %b", busy, busy2);
        end
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL repeat_timeout: got pending words required none"); end
        checks++;
        if (oe_low - o0 !== oe_exp || rdata !== 16'h1234) begin
            errors++;
            $display("FAIL repeat_read: got oe_cycles=%0d rdata=%h required %0d/1234", oe_low - o0, rdata, oe_exp);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_first();
        test_burst();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_cache();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion required finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
